// File: rtl/mp3_audio_pkg.sv
// mp3_audio_pkg: shared audio-path defaults and I2S slot encoding
package mp3_audio_pkg;
  localparam int SAMPLE_W_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int SLOT_W_DEF = 32;
  typedef enum logic {SLOT_LEFT = 1'b0, SLOT_RIGHT = 1'b1} slot_e;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: circular sample buffer with the head word visible without read latency
module sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [AW:0]  o_level,
  output logic         o_full,
  output logic         o_empty
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  logic w_push, w_pop;
  assign o_full = r_level == FULL_LVL;
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_data = r_mem[r_rptr];
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop = i_pop & ~o_empty & ~i_flush;
  // storage needs no reset: pointers and level define which words are live
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wptr] <= i_data;
  // pointers wrap naturally because the depth is a power of two; flush empties at once
  always_ff @(posedge i_clk)
    if (!i_rst_n || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= (w_push && !w_pop) ? r_level + 1'b1 : (w_pop && !w_push) ? r_level - 1'b1 : r_level;
    end
endmodule

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: buffers mono samples and serialises them as I2S data for a codec-mastered clock pair
module i2s_sample_tx
  import mp3_audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         enable,
  input  logic [SAMPLE_W-1:0]          sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         lrclk_i,
  input  logic                         bclk_i,
  output logic                         sdata_o,
  input  logic                         clear_underrun,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int PAD_W = SLOT_W - SAMPLE_W;
  logic r_lr_s1, r_lr_s2, r_bclk_s1, r_bclk_s2, r_bclk_s3, r_lr_prev;
  logic [SLOT_W-1:0] r_shreg;
  logic [SAMPLE_W-1:0] r_cur;
  logic r_sdata, r_underrun;
  logic w_bclk_fall, w_load, w_left, w_pop, w_push, w_full, w_empty;
  logic [SAMPLE_W-1:0] w_head, w_word;
  assign w_bclk_fall = r_bclk_s3 & ~r_bclk_s2;
  assign w_load = w_bclk_fall & (r_lr_s2 != r_lr_prev);
  assign w_left = w_load & (slot_e'(r_lr_s2) == SLOT_LEFT);
  assign w_pop = w_left & enable & ~w_empty;
  assign sample_ready = enable & ~w_full;
  assign w_push = sample_valid & sample_ready;
  assign w_word = w_left ? (w_pop ? w_head : '0) : r_cur;
  assign sdata_o = r_sdata;
  assign underrun = r_underrun;
  sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (~enable),
    .i_data  (sample_data),
    .o_data  (w_head),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // two-flop synchronisers plus a delayed BCLK copy; preset high so the first LRCLK fall starts a left slot
  always_ff @(posedge Clk)
    if (!Reset_n) {r_lr_s1, r_lr_s2, r_bclk_s1, r_bclk_s2, r_bclk_s3} <= '1;
    else begin
      r_lr_s1 <= lrclk_i;
      r_lr_s2 <= r_lr_s1;
      r_bclk_s1 <= bclk_i;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_s3 <= r_bclk_s2;
    end
  // on each BCLK fall either load a new slot (pad bit out first) or shift the next bit out
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      r_lr_prev <= 1'b1;
      r_shreg <= '0;
      r_cur <= '0;
      r_sdata <= 1'b0;
    end else if (w_load) begin
      r_lr_prev <= r_lr_s2;
      r_shreg <= {w_word, {PAD_W{1'b0}}};
      r_sdata <= 1'b0;
      if (w_left) r_cur <= w_word;
    end else if (w_bclk_fall) begin
      r_sdata <= r_shreg[SLOT_W-1];
      r_shreg <= {r_shreg[SLOT_W-2:0], 1'b0};
    end
  // sticky underrun: a starved left load wins over a same-cycle clear
  always_ff @(posedge Clk)
    if (!Reset_n) r_underrun <= 1'b0;
    else if (w_left && enable && w_empty) r_underrun <= 1'b1;
    else if (clear_underrun) r_underrun <= 1'b0;
endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: randomized frame-level scoreboard for the I2S sample transmitter
module tb_i2s_sample_tx;
  localparam int SW = 16;
  localparam int DEPTH = 8;
  localparam int SLOT = 32;
  localparam int HALF = 8;
  logic Clk = 0, Reset_n = 0, enable = 0, sample_valid = 0, lrclk_i = 1, bclk_i = 1, clear_underrun = 0;
  logic [SW-1:0] sample_data = '0;
  logic sample_ready, sdata_o, underrun;
  logic [3:0] fifo_level;
  int total = 0, bad = 0;
  bit exp_q[$];
  int model_q[$];
  int cur = 0;
  bit exp_ur = 0, mon_en = 0, mon_exp;

  i2s_sample_tx #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .SLOT_W(SLOT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .lrclk_i(lrclk_i),
    .bclk_i(bclk_i), .sdata_o(sdata_o), .clear_underrun(clear_underrun),
    .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  always @(posedge bclk_i) if (mon_en) begin
    check("exp_avail", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("sdata_bit", sdata_o, mon_exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic push(input int d);
    bit acc;
    acc = enable && model_q.size() < DEPTH;
    sample_data = SW'(d);
    sample_valid = 1;
    check("ready", sample_ready, acc);
    tick(1);
    sample_valid = 0;
    if (acc) model_q.push_back(d);
  endtask

  task automatic load_slot(input bit lr, input int nper);
    int w;
    if (!lr) begin
      if (enable && model_q.size() > 0) w = model_q.pop_front();
      else begin
        w = 0;
        if (enable) exp_ur = 1;
      end
      cur = w;
    end else w = cur;
    for (int i = 0; i < nper; i++) exp_q.push_back((i >= 1 && i <= SW) ? w[SW-i] : 1'b0);
  endtask

  task automatic run_slot(input bit lr, input int nper, input int npush, input bit copush,
                          input bit hold, input int xd, input int rst_p, input int drop_p);
    int pre, k;
    bit acc;
    pre = model_q.size();
    load_slot(lr, nper);
    for (int p = 0; p < nper; p++) begin
      bclk_i = 0;
      if (p == 0) lrclk_i = lr;
      if (p == 0 && copush) begin
        tick(2);
        sample_data = SW'(xd);
        sample_valid = 1;
        tick(1);
        sample_valid = 0;
        if (enable && pre < DEPTH) model_q.push_back(xd);
        check("copush_level", fifo_level, model_q.size());
        tick(HALF - 3);
      end else if (p == 0 && hold) begin
        acc = 0;
        k = -1;
        sample_data = SW'(xd);
        sample_valid = 1;
        for (int i = 0; i < HALF; i++) begin
          if (!acc && sample_ready) begin
            acc = 1;
            k = i;
          end
          tick(1);
          if (acc) sample_valid = 0;
        end
        sample_valid = 0;
        model_q.push_back(xd);
        check("hold_accept", acc && k >= 1 && k <= 4, 1);
      end else if (p == rst_p) begin
        Reset_n = 0;
        tick(1);
        check("rst_sdata", sdata_o, 0);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun, 0);
        tick(1);
        Reset_n = 1;
        model_q.delete();
        cur = 0;
        exp_ur = 0;
        foreach (exp_q[i]) exp_q[i] = 0;
        tick(HALF - 2);
      end else if (p == drop_p) begin
        enable = 0;
        tick(1);
        model_q.delete();
        check("drop_level", fifo_level, 0);
        check("drop_ready", sample_ready, 0);
        tick(HALF - 1);
      end else if (p >= 20 && p < 20 + npush) begin
        push(int'($urandom_range(0, 65535)));
        tick(HALF - 1);
      end else tick(HALF);
      bclk_i = 1;
      tick(HALF);
    end
    check("slot_underrun", underrun, exp_ur);
    check("slot_level", fifo_level, model_q.size());
  endtask

  task automatic frame(input int nper, input int nl, input int nr);
    run_slot(0, nper, nl, 0, 0, 0, -1, -1);
    run_slot(1, nper, nr, 0, 0, 0, -1, -1);
  endtask

  task automatic clear_pulse();
    clear_underrun = 1;
    tick(1);
    clear_underrun = 0;
    exp_ur = 0;
    check("clear", underrun, 0);
  endtask

  initial begin
    int nper, sel;
    Reset_n = 0;
    enable = 1;
    tick(4);
    Reset_n = 1;
    tick(2);
    check("rst_sdata0", sdata_o, 0);
    check("rst_underrun0", underrun, 0);
    check("rst_level0", fifo_level, 0);
    check("rst_ready0", sample_ready, 1);
    mon_en = 1;
    push('h7FFF);
    push('h8001);
    check("level2", fifo_level, 2);
    frame(SLOT, 0, 0);
    frame(SLOT, 0, 0);
    frame(SLOT, 0, 0);
    clear_pulse();
    for (int i = 0; i < 9; i++) push(int'($urandom_range(0, 65535)));
    check("full_level", fifo_level, 8);
    check("full_ready", sample_ready, 0);
    run_slot(0, SLOT, 0, 0, 1, 'h1234, -1, -1);
    run_slot(1, SLOT, 0, 0, 0, 0, -1, -1);
    while (model_q.size() > 3) frame(SLOT, 0, 0);
    run_slot(0, SLOT, 0, 1, 0, 'h0F0F, -1, -1);
    run_slot(1, SLOT, 0, 0, 0, 0, -1, -1);
    for (int f = 0; f < 8; f++) begin
      sel = int'($urandom_range(0, 3));
      nper = (sel == 0) ? 24 : (sel == 1) ? 40 : SLOT;
      frame(nper, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) clear_pulse();
    end
    clear_pulse();
    while (model_q.size() > 6) frame(SLOT, 0, 0);
    while (model_q.size() < 6) push(int'($urandom_range(1, 65535)));
    run_slot(0, SLOT, 0, 0, 0, 0, -1, 10);
    run_slot(1, SLOT, 0, 0, 0, 0, -1, -1);
    frame(SLOT, 0, 0);
    enable = 1;
    tick(2);
    push('hA5A5);
    push('h5A5A);
    run_slot(0, SLOT, 0, 0, 0, 0, -1, -1);
    run_slot(1, SLOT, 2, 0, 0, 0, 5, -1);
    frame(SLOT, 0, 0);
    tick(4);
    mon_en = 0;
    check("leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
